// File: rtl/sky_stacker_pkg.sv
// Shared definitions for the Sky-Stacker timing blocks: lifecycle state
// encoding, level field defaults and the short divider values used when
// SKY_STACKER_SIM_FAST_EN is defined.
package sky_stacker_pkg;

    // Level field defaults
    localparam int LVL_W_DEF      = 3;
    localparam int NUM_LEVELS_DEF = 8;

    // Divider values substituted for short simulations
    localparam int FAST_BASE_DIV  = 16;
    localparam int FAST_MIN_DIV   = 2;

    // Game lifecycle states; encoding is visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/step_period_lut.sv
// Step period per difficulty level: BASE_DIV halved once per level,
// clamped below at MIN_DIV. Purely combinational so the display can reuse
// it for a speed indicator.
module step_period_lut #(
    parameter int BASE_DIV = 50000000,
    parameter int MIN_DIV  = 3125000,
    parameter int CNT_W    = 26,
    parameter int LVL_W    = 3
) (
    input  logic [LVL_W-1:0] level,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] BASE_VAL = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] MIN_VAL  = CNT_W'(MIN_DIV);

    logic [CNT_W-1:0] shifted_s;

    // Halve the base period per level, never going below the floor
    always_comb begin
        shifted_s = BASE_VAL >> level;
        if (shifted_s < MIN_VAL) begin
            period = MIN_VAL;
        end else begin
            period = shifted_s;
        end
    end

endmodule

// File: rtl/fall_step_scheduler.sv
// Sky-Stacker fall/step scheduler: produces a one-cycle step_en at each
// step boundary of the current level's period and sequences the
// IDLE -> RUN <-> PAUSED -> DONE lifecycle.
// Build option: SKY_STACKER_SIM_FAST_EN replaces BASE_DIV/MIN_DIV with the
// short package values (16 / 2); timing rules and priorities are unchanged.
module fall_step_scheduler
    import sky_stacker_pkg::*;
#(
    parameter int BASE_DIV   = 50000000,
    parameter int MIN_DIV    = 3125000,
    parameter int NUM_LEVELS = NUM_LEVELS_DEF,
    parameter int CNT_W      = 26,
    parameter int LVL_W      = LVL_W_DEF
) (
    input  logic             master_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             level_up,
    input  logic             game_over,
    output logic             step_en,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       state,
    output logic             running
);

`ifdef SKY_STACKER_SIM_FAST_EN
    localparam bit SIM_FAST = 1'b1;
`else
    localparam bit SIM_FAST = 1'b0;
`endif

    localparam int EFF_BASE_DIV = SIM_FAST ? FAST_BASE_DIV : BASE_DIV;
    localparam int EFF_MIN_DIV  = SIM_FAST ? FAST_MIN_DIV  : MIN_DIV;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);

    sched_state_e     state_r;
    sched_state_e     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [LVL_W-1:0] level_inc_s;
    logic             step_en_r;
    logic             step_nxt_s;
    logic             running_r;
    logic [CNT_W-1:0] period_s;
    logic             terminal_s;

    step_period_lut #(
        .BASE_DIV (EFF_BASE_DIV),
        .MIN_DIV  (EFF_MIN_DIV),
        .CNT_W    (CNT_W),
        .LVL_W    (LVL_W)
    ) u_period (
        .level    (level_r),
        .period   (period_s)
    );

    // Terminal count of the current period and saturating next level
    always_comb begin
        terminal_s = (cnt_r == (period_s - CNT_ONE));
        if (level_r == LVL_MAX) begin
            level_inc_s = level_r;
        end else begin
            level_inc_s = level_r + LVL_ONE;
        end
    end

    // Lifecycle transitions plus counter/level/step decisions; game_over
    // dominates, then pause, then normal counting with level_up
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        step_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = LVL_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_nxt_s = ST_DONE;
                end else if (pause) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    if (terminal_s) begin
                        step_nxt_s = 1'b1;
                        cnt_nxt_s  = CNT_ZERO;
                    end else begin
                        cnt_nxt_s  = cnt_r + CNT_ONE;
                    end
                    // A level change restarts the period at the new rate
                    if (level_up) begin
                        cnt_nxt_s   = CNT_ZERO;
                        level_nxt_s = level_inc_s;
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    state_nxt_s = ST_DONE;
                end else if (pause) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = LVL_ZERO;
            end
        endcase
    end

    // State, counter, level and registered outputs
    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            level_r   <= LVL_ZERO;
            step_en_r <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            step_en_r <= step_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign step_en = step_en_r;
    assign level   = level_r;
    assign state   = state_r;
    assign running = running_r;

endmodule
